// File: rtl/pa_ahbl_slv_pkg.sv
// Shared AHB-Lite encodings and the responder FSM state type for the pa_ahbl_slv_* blocks.
package pa_ahbl_slv_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

endpackage

// File: rtl/pa_ahbl_slv_bstrb.sv
// Combinational hsize/addr[1:0] decode into byte-lane strobes plus a misalignment flag.
// Illegal sizes (>word) yield no strobes; the caller flags them separately.
module pa_ahbl_slv_bstrb
  import pa_ahbl_slv_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb,
  output logic       misalign
);

  always_comb begin
    strb     = 4'b0000;
    misalign = 1'b0;
    case (hsize)
      HSIZE_BYTE: strb = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        strb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign = addr_lo[0];
      end
      HSIZE_WORD: begin
        strb     = 4'b1111;
        misalign = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pa_ahbl_slv_mem.sv
// AHB-Lite responder onto a word-organised RAM; data phase takes 1+WAIT_CYC cycles, ERROR is two cycles.
// Stalls the bus via hreadyout only; optional privileged region check under PA_AHBL_SLV_PRIV_CHK_EN.
module pa_ahbl_slv_mem
  import pa_ahbl_slv_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned WAIT_CYC   = 0,
  parameter int unsigned PRIV_WORDS = 512
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        pad_slv_hsel,
  input  logic [31:0] pad_slv_haddr,
  input  logic [1:0]  pad_slv_htrans,
  input  logic        pad_slv_hwrite,
  input  logic [2:0]  pad_slv_hsize,
  input  logic [2:0]  pad_slv_hburst,
  input  logic [3:0]  pad_slv_hprot,
  input  logic        pad_slv_hlock,
  input  logic [31:0] pad_slv_hwdata,
  input  logic        pad_slv_hready,
  output logic [31:0] slv_pad_hrdata,
  output logic        slv_pad_hreadyout,
  output logic        slv_pad_hresp
);

  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam logic [2:0]  WAIT_LD = 3'(WAIT_CYC);

  state_t              state, state_nxt;
  logic [2:0]          wait_cnt, wait_cnt_nxt;
  logic                dp_vld;
  logic [ADDR_W+1:0]   dp_addr;
  logic                dp_write;
  logic [2:0]          dp_size;
  logic [31:0]         rdata_hold;
  logic [31:0]         mem [DEPTH];

  logic                accept, acc_err, acc_misalign, size_bad, range_bad, priv_bad;
  logic [3:0]          acc_strb_unused;
  logic [3:0]          dp_strb;
  logic                dp_misalign_unused;
  logic                dp_done;
  logic [ADDR_W-1:0]   dp_word;
  logic [31:0]         rd_word;
  logic                unused_ok;

  assign slv_pad_hreadyout = (state == ST_IDLE) || (state == ST_ERR2);
  assign slv_pad_hresp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

  assign accept = pad_slv_hsel & pad_slv_htrans[1] & pad_slv_hready & slv_pad_hreadyout;

  pa_ahbl_slv_bstrb u_acc_bstrb (
    .hsize    (pad_slv_hsize),
    .addr_lo  (pad_slv_haddr[1:0]),
    .strb     (acc_strb_unused),
    .misalign (acc_misalign)
  );

  pa_ahbl_slv_bstrb u_dp_bstrb (
    .hsize    (dp_size),
    .addr_lo  (dp_addr[1:0]),
    .strb     (dp_strb),
    .misalign (dp_misalign_unused)
  );

  assign size_bad  = pad_slv_hsize > HSIZE_WORD;
  assign range_bad = |pad_slv_haddr[31:ADDR_W+2];

`ifdef PA_AHBL_SLV_PRIV_CHK_EN
  assign priv_bad = ~pad_slv_hprot[1] &&
                    (32'(pad_slv_haddr[ADDR_W+1:2]) >= 32'(PRIV_WORDS));
`else
  assign priv_bad = 1'b0;
`endif

  assign acc_err = size_bad | acc_misalign | range_bad | priv_bad;

  // ERR2 shares IDLE's acceptance path so a new transfer can overlap the second ERROR cycle.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_IDLE, ST_ERR2: begin
        state_nxt = ST_IDLE;
        if (accept) begin
          if (acc_err) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_LD != 3'd0) begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = WAIT_LD;
          end
        end
      end
      ST_WAIT: begin
        wait_cnt_nxt = wait_cnt - 3'd1;
        if (wait_cnt == 3'd1) state_nxt = ST_IDLE;
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign dp_done = dp_vld & (state == ST_IDLE);
  assign dp_word = dp_addr[ADDR_W+1:2];
  assign rd_word = mem[dp_word];

  // Array read is combinational, so a read right behind a write to the same word sees the new data.
  assign slv_pad_hrdata = (dp_done & ~dp_write) ? rd_word : rdata_hold;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state      <= ST_IDLE;
      wait_cnt   <= 3'd0;
      dp_vld     <= 1'b0;
      dp_addr    <= '0;
      dp_write   <= 1'b0;
      dp_size    <= 3'd0;
      rdata_hold <= 32'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (slv_pad_hreadyout) begin
        dp_vld <= accept & ~acc_err;
        if (accept) begin
          dp_addr  <= pad_slv_haddr[ADDR_W+1:0];
          dp_write <= pad_slv_hwrite;
          dp_size  <= pad_slv_hsize;
        end
      end
      if (dp_done & ~dp_write) rdata_hold <= rd_word;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (dp_done & dp_write) begin
      for (int b = 0; b < 4; b++) begin
        if (dp_strb[b]) mem[dp_word][8*b +: 8] <= pad_slv_hwdata[8*b +: 8];
      end
    end
  end

  assign unused_ok = ^{pad_slv_hburst, pad_slv_hlock, pad_slv_hprot, pad_slv_htrans[0],
                       acc_strb_unused, dp_misalign_unused};

endmodule

// File: tb/tb_pa_ahbl_slv_mem.sv
// Directed bench: one zero-wait and one three-wait-state responder on a shared bus.
module tb_pa_ahbl_slv_mem;

  logic        clk;
  logic        cpurst_b;
  logic        hsel0, hsel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hlock;
  logic [31:0] hwdata;
  logic        ext_rdy;
  logic        hready0, hready3;
  logic [31:0] hrdata0, hrdata3;
  logic        hreadyout0, hreadyout3;
  logic        hresp0, hresp3;

  int errors = 0;
  int checks = 0;

  assign hready0 = hreadyout0 & ext_rdy;
  assign hready3 = hreadyout3 & ext_rdy;

  pa_ahbl_slv_mem #(.ADDR_W(10), .WAIT_CYC(0), .PRIV_WORDS(512)) u_dut0 (
    .forever_cpuclk    (clk),
    .cpurst_b          (cpurst_b),
    .pad_slv_hsel      (hsel0),
    .pad_slv_haddr     (haddr),
    .pad_slv_htrans    (htrans),
    .pad_slv_hwrite    (hwrite),
    .pad_slv_hsize     (hsize),
    .pad_slv_hburst    (hburst),
    .pad_slv_hprot     (hprot),
    .pad_slv_hlock     (hlock),
    .pad_slv_hwdata    (hwdata),
    .pad_slv_hready    (hready0),
    .slv_pad_hrdata    (hrdata0),
    .slv_pad_hreadyout (hreadyout0),
    .slv_pad_hresp     (hresp0)
  );

  pa_ahbl_slv_mem #(.ADDR_W(10), .WAIT_CYC(3), .PRIV_WORDS(512)) u_dut3 (
    .forever_cpuclk    (clk),
    .cpurst_b          (cpurst_b),
    .pad_slv_hsel      (hsel3),
    .pad_slv_haddr     (haddr),
    .pad_slv_htrans    (htrans),
    .pad_slv_hwrite    (hwrite),
    .pad_slv_hsize     (hsize),
    .pad_slv_hburst    (hburst),
    .pad_slv_hprot     (hprot),
    .pad_slv_hlock     (hlock),
    .pad_slv_hwdata    (hwdata),
    .pad_slv_hready    (hready3),
    .slv_pad_hrdata    (hrdata3),
    .slv_pad_hreadyout (hreadyout3),
    .slv_pad_hresp     (hresp3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s0, input logic s3, input logic [31:0] a,
                       input logic w, input logic [2:0] sz, input logic [3:0] pr);
    hsel0  = s0;
    hsel3  = s3;
    haddr  = a;
    htrans = 2'b10;
    hwrite = w;
    hsize  = sz;
    hprot  = pr;
  endtask

  task automatic bus_idle();
    hsel0  = 1'b0;
    hsel3  = 1'b0;
    htrans = 2'b00;
  endtask

  // Steps until the wait-state responder is ready, returning how many low cycles were seen (20 = stuck).
  task automatic wait3(output int low);
    low = 0;
    while (!hreadyout3 && low < 20) begin
      low++;
      step();
    end
  endtask

  task automatic test_reset();
    cpurst_b = 1'b0;
    ext_rdy  = 1'b1;
    hburst   = 3'd0;
    hlock    = 1'b0;
    hwdata   = 32'd0;
    hprot    = 4'b0011;
    hwrite   = 1'b0;
    hsize    = 3'd2;
    haddr    = 32'd0;
    bus_idle();
    #12;
    checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL reset_rdy0: got %b want 1", hreadyout0); end
    checks++; if (hresp0 !== 1'b0) begin errors++; $display("FAIL reset_resp0: got %b want 0", hresp0); end
    checks++; if (hrdata0 !== 32'd0) begin errors++; $display("FAIL reset_rdata0: got %h want 0", hrdata0); end
    checks++; if (hreadyout3 !== 1'b1) begin errors++; $display("FAIL reset_rdy3: got %b want 1", hreadyout3); end
    checks++; if (hrdata3 !== 32'd0) begin errors++; $display("FAIL reset_rdata3: got %h want 0", hrdata3); end
    @(negedge clk);
    cpurst_b = 1'b1;
    step();
  endtask

  task automatic test_word_rw();
    drive(1, 0, 32'h10, 1, 3'd2, 4'b0011);
    step();
    hwdata = 32'hDEAD_BEEF;
    drive(1, 0, 32'h10, 0, 3'd2, 4'b0011);
    checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL wr_rdy: got %b want 1", hreadyout0); end
    checks++; if (hresp0 !== 1'b0) begin errors++; $display("FAIL wr_resp: got %b want 0", hresp0); end
    step();
    bus_idle();
    checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL rd_rdy: got %b want 1", hreadyout0); end
    checks++; if (hrdata0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_rd: got %h want deadbeef", hrdata0); end
    step();
  endtask

  task automatic test_byte_half();
    drive(1, 0, 32'h10, 1, 3'd2, 4'b0011);
    step();
    hwdata = 32'h1122_3344;
    drive(1, 0, 32'h13, 1, 3'd0, 4'b0011);
    step();
    hwdata = 32'hA577_6655;
    drive(1, 0, 32'h14, 1, 3'd2, 4'b0011);
    step();
    hwdata = 32'h0000_0000;
    drive(1, 0, 32'h16, 1, 3'd1, 4'b0011);
    step();
    hwdata = 32'hCAFE_1234;
    drive(1, 0, 32'h10, 0, 3'd2, 4'b0011);
    step();
    drive(1, 0, 32'h14, 0, 3'd2, 4'b0011);
    checks++; if (hrdata0 !== 32'hA522_3344) begin errors++; $display("FAIL byte_wr: got %h want a5223344", hrdata0); end
    step();
    bus_idle();
    checks++; if (hrdata0 !== 32'hCAFE_0000) begin errors++; $display("FAIL half_wr: got %h want cafe0000", hrdata0); end
    step();
  endtask

  task automatic test_wait_states();
    int low;
    drive(0, 1, 32'h20, 1, 3'd2, 4'b0011);
    step();
    hwdata = 32'h1234_5678;
    drive(0, 1, 32'h20, 0, 3'd2, 4'b0011);
    checks++; if (hreadyout3 !== 1'b0) begin errors++; $display("FAIL wait_first: got %b want 0", hreadyout3); end
    wait3(low);
    checks++; if (low !== 3) begin errors++; $display("FAIL wait_wr_len: got %0d want 3", low); end
    step();
    bus_idle();
    checks++; if (hrdata3 !== 32'd0) begin errors++; $display("FAIL wait_hold: got %h want 0", hrdata3); end
    wait3(low);
    checks++; if (low !== 3) begin errors++; $display("FAIL wait_rd_len: got %0d want 3", low); end
    checks++; if (hrdata3 !== 32'h1234_5678) begin errors++; $display("FAIL wait_rd: got %h want 12345678", hrdata3); end
    checks++; if (hresp3 !== 1'b0) begin errors++; $display("FAIL wait_resp: got %b want 0", hresp3); end
    step();
    checks++; if (hrdata3 !== 32'h1234_5678) begin errors++; $display("FAIL wait_rd_hold: got %h want 12345678", hrdata3); end
  endtask

  task automatic test_error();
    drive(1, 0, 32'h0, 1, 3'd2, 4'b0011);
    step();
    hwdata = 32'h0BAD_F00D;
    drive(1, 0, 32'h40, 1, 3'd2, 4'b0011);
    step();
    hwdata = 32'h55AA_55AA;
    drive(1, 0, 32'h42, 1, 3'd2, 4'b0011);
    step();
    hwdata = 32'hFFFF_FFFF;
    bus_idle();
    checks++; if ({hreadyout0, hresp0} !== 2'b01) begin errors++; $display("FAIL mis_err1: got %b want 01", {hreadyout0, hresp0}); end
    step();
    checks++; if ({hreadyout0, hresp0} !== 2'b11) begin errors++; $display("FAIL mis_err2: got %b want 11", {hreadyout0, hresp0}); end
    drive(1, 0, 32'h1000, 1, 3'd2, 4'b0011);
    step();
    bus_idle();
    checks++; if ({hreadyout0, hresp0} !== 2'b01) begin errors++; $display("FAIL rng_err1: got %b want 01", {hreadyout0, hresp0}); end
    step();
    checks++; if ({hreadyout0, hresp0} !== 2'b11) begin errors++; $display("FAIL rng_err2: got %b want 11", {hreadyout0, hresp0}); end
    drive(1, 0, 32'h40, 1, 3'd3, 4'b0011);
    step();
    bus_idle();
    checks++; if ({hreadyout0, hresp0} !== 2'b01) begin errors++; $display("FAIL size_err1: got %b want 01", {hreadyout0, hresp0}); end
    step();
    drive(1, 0, 32'h40, 0, 3'd2, 4'b0011);
    step();
    drive(1, 0, 32'h0, 0, 3'd2, 4'b0011);
    checks++; if ({hreadyout0, hresp0} !== 2'b10) begin errors++; $display("FAIL err_recover: got %b want 10", {hreadyout0, hresp0}); end
    checks++; if (hrdata0 !== 32'h55AA_55AA) begin errors++; $display("FAIL err_nowrite: got %h want 55aa55aa", hrdata0); end
    step();
    bus_idle();
    checks++; if (hrdata0 !== 32'h0BAD_F00D) begin errors++; $display("FAIL rng_alias: got %h want 0badf00d", hrdata0); end
    step();
  endtask

  task automatic test_hready_low();
    ext_rdy = 1'b0;
    drive(1, 0, 32'h40, 1, 3'd2, 4'b0011);
    step();
    hwdata = 32'h0;
    bus_idle();
    checks++; if ({hreadyout0, hresp0} !== 2'b10) begin errors++; $display("FAIL hrdy_low: got %b want 10", {hreadyout0, hresp0}); end
    ext_rdy = 1'b1;
    step();
    drive(1, 0, 32'h40, 0, 3'd2, 4'b0011);
    step();
    bus_idle();
    checks++; if (hrdata0 !== 32'h55AA_55AA) begin errors++; $display("FAIL hrdy_nowrite: got %h want 55aa55aa", hrdata0); end
    step();
  endtask

  task automatic test_priv();
`ifdef PA_AHBL_SLV_PRIV_CHK_EN
    drive(1, 0, 32'h800, 1, 3'd2, 4'b0001);
    step();
    hwdata = 32'hBAD0_BAD0;
    bus_idle();
    checks++; if ({hreadyout0, hresp0} !== 2'b01) begin errors++; $display("FAIL priv_user: got %b want 01", {hreadyout0, hresp0}); end
    step();
    drive(1, 0, 32'h800, 1, 3'd2, 4'b0011);
    step();
`else
    drive(1, 0, 32'h800, 1, 3'd2, 4'b0001);
    step();
`endif
    hwdata = 32'h600D_CAFE;
    checks++; if ({hreadyout0, hresp0} !== 2'b10) begin errors++; $display("FAIL priv_okay: got %b want 10", {hreadyout0, hresp0}); end
    drive(1, 0, 32'h800, 0, 3'd2, 4'b0011);
    step();
    bus_idle();
    checks++; if (hrdata0 !== 32'h600D_CAFE) begin errors++; $display("FAIL priv_rd: got %h want 600dcafe", hrdata0); end
    step();
  endtask

  task automatic test_reset_mid();
    int low;
    drive(0, 1, 32'h30, 1, 3'd2, 4'b0011);
    step();
    hwdata = 32'h1111_1111;
    bus_idle();
    wait3(low);
    step();
    drive(0, 1, 32'h30, 1, 3'd2, 4'b0011);
    step();
    hwdata = 32'h2222_2222;
    bus_idle();
    step();
    cpurst_b = 1'b0;
    #1;
    checks++; if ({hreadyout3, hresp3} !== 2'b10) begin errors++; $display("FAIL rst_mid: got %b want 10", {hreadyout3, hresp3}); end
    step();
    cpurst_b = 1'b1;
    step();
    drive(0, 1, 32'h30, 0, 3'd2, 4'b0011);
    step();
    bus_idle();
    wait3(low);
    checks++; if (hrdata3 !== 32'h1111_1111) begin errors++; $display("FAIL rst_drop: got %h want 11111111", hrdata3); end
    step();
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_half();
    test_wait_states();
    test_error();
    test_hready_low();
    test_priv();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pa_ahbl_slv_mem.md
Name: pa_ahbl_slv_mem

Overview:
AHB-Lite responder (slave) that terminates the core's instruction/data AHB-Lite master port in a word-organised on-chip memory. Used as the bench and system-level target for the core's AHB-Lite bus interface, and as a small boot/scratch RAM in subsystem configs. Supports byte/half/word accesses, programmable wait states and the two-cycle ERROR response.

Parameters:
ADDR_W, 10, word-address width; memory depth = 2^ADDR_W 32-bit words; byte range = 4*2^ADDR_W.
WAIT_CYC, 0, wait states inserted per OKAY data phase (0..7).
PRIV_WORDS, 512, word offset at and above which the region is privileged-only (used only with the optional feature).

Ports:
forever_cpuclk  in  1  clock; one clock, all flops on rising edge
cpurst_b  in  1  reset, asynchronous, active-low
pad_slv_hsel  in  1  slave select
pad_slv_haddr  in  32  address
pad_slv_htrans  in  2  IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
pad_slv_hwrite  in  1  1=write
pad_slv_hsize  in  3  0=byte 1=half 2=word
pad_slv_hburst  in  3  accepted, ignored
pad_slv_hprot  in  4  hprot[1]=1 privileged
pad_slv_hlock  in  1  accepted, ignored
pad_slv_hwdata  in  32  write data (data phase)
pad_slv_hready  in  1  bus HREADY (HREADYIN)
slv_pad_hrdata  out  32  read data
slv_pad_hreadyout  out  1  transfer done
slv_pad_hresp  out  1  0=OKAY 1=ERROR

Behaviour:
- Reset: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, all address-phase regs cleared, wait counter 0. Memory contents not reset.
- Address phase accepted iff hsel & htrans[1] & hready. Register addr[ADDR_W+1:0], hwrite, hsize, hprot; otherwise data-phase valid flag cleared.
- IDLE/BUSY or unselected: zero-wait OKAY (hreadyout=1, hresp=0).
- Error check at accept: hsize>2, misaligned (half with addr[0]=1, word with addr[1:0]!=0), or addr beyond byte range -> ERROR path; memory untouched.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  IDLE: on accepted legal transfer with WAIT_CYC=0 stay in data phase with hreadyout=1; WAIT_CYC>0 -> WAIT, counter loaded with WAIT_CYC.
  WAIT: hreadyout=0; decrement each cycle; at counter==1 next cycle hreadyout=1 (data phase completes), return to IDLE/accept next.
  ERR1: hreadyout=0, hresp=1 (one cycle) -> ERR2.
  ERR2: hreadyout=1, hresp=1; next address phase may be accepted this cycle; then IDLE.
- Latency: read/write data phase = 1+WAIT_CYC cycles.
- Write: byte strobes from registered hsize/addr[1:0]; array updated on the cycle hreadyout=1 using hwdata lanes.
- Read: hrdata = full word at registered address, valid in the hreadyout=1 cycle; hrdata holds last value otherwise. Byte/half reads return full word (master selects lanes).
- Back-to-back write then read same address: the read must return the new data (write committed at end of write data phase, read sampled in following cycle); no bypass required at WAIT_CYC=0 given combinational array read.
- New address phase is only accepted while hreadyout=1 (pipelined acceptance in the final data-phase cycle).
- hready low from another slave while this slave idle: no acceptance, outputs stay OKAY/ready.
- Reset mid-transfer: FSM immediately IDLE, pending write dropped.

Optional Feature:
PA_AHBL_SLV_PRIV_CHK_EN: defined -> access with hprot[1]=0 to word offset >= PRIV_WORDS takes the ERROR path (no write). Undefined -> hprot ignored, PRIV_WORDS unused.

Decomposition:
- Package pa_ahbl_slv_pkg: HTRANS codes, HRESP codes, HSIZE codes, FSM state encoding.
- One sub-module pa_ahbl_slv_bstrb: combinational hsize/addr[1:0] -> 4-bit byte strobe plus misalign flag.

Test Plan:
- WAIT_CYC=0: NONSEQ word write 0x0000_0010 <- 0xDEAD_BEEF, then NONSEQ read -> hrdata=0xDEAD_BEEF, hreadyout never low.
- Byte write 0xA5 to 0x13 over word 0x1122_3344 -> read 0x10 returns 0xA522_3344.
- WAIT_CYC=3: read -> hreadyout low exactly 3 cycles, data in 4th; next NONSEQ accepted in that cycle.
- Address 4*2^ADDR_W, or word access at 0x2 -> hresp=1/hreadyout=0 one cycle, then hresp=1/hreadyout=1; memory unchanged.
- With PA_AHBL_SLV_PRIV_CHK_EN: user write (hprot=4'b0001) to word 512 -> ERROR; privileged (hprot=4'b0011) -> OKAY.
- cpurst_b asserted during WAIT -> hreadyout=1, hresp=0 next sample; write discarded.
